multicycle_ctrl: RTL and testbench

//  Control FSM for the multi-cycle MIPS datapath: sequences the shared ALU, register file and unified memory

---
 rtl/cpu_defs_pkg.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multi-cycle CPU: opcodes, datapath select codes, FSM states, error codes.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_R_WB      = 4'd4,
    S_EXEC_I    = 4'd5,
    S_I_WB      = 4'd6,
    S_MEM_ADDR  = 4'd7,
    S_MEM_READ  = 4'd8,
    S_MEM_WB    = 4'd9,
    S_MEM_WRITE = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd15
  } state_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: one datapath step per state, IF/ID/EX/MEM/WB.
// Latency: CPI 3-5 plus memory wait cycles; controls are Moore except ready/zero-gated strobes.
// Backpressure: memory stalls via mem_ready_i, bounded by MEM_TIMEOUT before halting.
module multicycle_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             IorD_o,
  output logic             IRWrite_o,
  output logic             pc_we_o,
  output logic [1:0]       PCSource_o,
  output logic             RegDst_o,
  output logic             MemtoReg_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic             halt_o,
  output logic [1:0]       err_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [3:0]       state_o
);

  localparam int STALL_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(MEM_TIMEOUT);

  state_t               state_q, state_d;
  logic [STALL_W-1:0]   stall_q;
  logic [1:0]           err_q, err_d;
  logic [CNT_W-1:0]     retired_q;
  logic                 retire;
  logic                 timed_out;

  // Only meaningful while a request is outstanding; ready in the limit cycle still completes.
  assign timed_out = (MEM_TIMEOUT > 0) && (stall_q == STALL_LIM) && !mem_ready_i;

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    retire     = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    IorD_o     = 1'b0;
    IRWrite_o  = 1'b0;
    pc_we_o    = 1'b0;
    PCSource_o = PCSRC_ALU;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    RegWrite_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = SRCB_RT;
    ALUOp_o    = ALUOP_ADD;
    halt_o     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          pc_we_o   = 1'b1;
          state_d   = S_DECODE;
        end else if (timed_out) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        ALUSrcB_o = SRCB_IMM_SH2;
        case (op_i)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_HALT;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_FUNCT;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        RegWrite_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = (op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req_o = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) begin
          state_d = S_MEM_WB;
        end else if (timed_out) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_MEM_WB: begin
        MemtoReg_o = 1'b1;
        RegWrite_o = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        IorD_o    = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_HALT;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_BRANCH: begin
        ALUSrcA_o  = 1'b1;
        ALUOp_o    = ALUOP_SUB;
        PCSource_o = PCSRC_ALUOUT;
        pc_we_o    = zero_i;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_we_o    = 1'b1;
        PCSource_o = PCSRC_JUMP;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halt_o = 1'b1;
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      stall_q   <= '0;
      err_q     <= ERR_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      // Any cycle without an outstanding wait restarts the count for the next access.
      if (mem_req_o && !mem_ready_i) stall_q <= stall_q + STALL_W'(1);
      else                           stall_q <= '0;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign err_o     = err_q;
  assign retired_o = retired_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed step checks plus a randomized instruction stream
// compared against an instruction-level model (CPI, access counts, strobe counts).
module tb_multicycle_ctrl;
  import cpu_defs_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, zero_i, mem_ready_i;
  logic [5:0]  op_i;
  logic        mem_req_o, mem_we_o, IorD_o, IRWrite_o, pc_we_o;
  logic [1:0]  PCSource_o;
  logic        RegDst_o, MemtoReg_o, RegWrite_o, ALUSrcA_o;
  logic [1:0]  ALUSrcB_o, ALUOp_o;
  logic        halt_o;
  logic [1:0]  err_o;
  logic [31:0] retired_o;
  logic [3:0]  state_o;

  int n_total = 0;
  int n_bad   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .IorD_o(IorD_o),
    .IRWrite_o(IRWrite_o), .pc_we_o(pc_we_o), .PCSource_o(PCSource_o), .RegDst_o(RegDst_o),
    .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o), .halt_o(halt_o), .err_o(err_o),
    .retired_o(retired_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction-level reference: cycles per instruction with zero-wait memory.
  function automatic int ref_cpi(input logic [5:0] op);
    case (op)
      OP_LW:        return 5;
      OP_BEQ, OP_J: return 3;
      default:      return 4;
    endcase
  endfunction

  function automatic bit ref_is_mem(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic [14:0] all_strobes();
    return {mem_req_o, mem_we_o, IorD_o, IRWrite_o, pc_we_o, PCSource_o, RegDst_o,
            MemtoReg_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o};
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0; op_i = '0; zero_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic start_cpu();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Plays memory and IR for one instruction starting in FETCH; returns what was observed.
  task automatic run_instr(input logic [5:0] op, input logic zr, input int fw, input int mw,
                           output int cyc, output int reqc, output int wec, output int pcwec,
                           output int regwc, output logic rw_m2r, output logic rw_dst,
                           output logic [1:0] last_pcsrc, output logic done);
    logic [31:0] ret0;
    logic        irw_seen;
    int          fl, ml;
    ret0 = retired_o; cyc = 0; reqc = 0; wec = 0; pcwec = 0; regwc = 0;
    rw_m2r = 1'b0; rw_dst = 1'b0; last_pcsrc = 2'b00; done = 1'b0;
    irw_seen = 1'b0; fl = fw; ml = mw; zero_i = zr;
    while (cyc < 100) begin
      if (cyc > 0 && retired_o != ret0) begin
        done = 1'b1;
        break;
      end
      if (halt_o) break;
      if (irw_seen) op_i = op;
      start_i = 1'($urandom);
      if (mem_req_o) begin
        if (IorD_o) begin mem_ready_i = (ml == 0); if (ml > 0) ml--; end
        else        begin mem_ready_i = (fl == 0); if (fl > 0) fl--; end
      end else begin
        mem_ready_i = 1'($urandom);
      end
      #1;
      if (mem_req_o) reqc++;
      if (mem_we_o)  wec++;
      if (pc_we_o)   begin pcwec++; last_pcsrc = PCSource_o; end
      if (RegWrite_o) begin regwc++; rw_m2r = MemtoReg_o; rw_dst = RegDst_o; end
      if (IRWrite_o) irw_seen = 1'b1;
      cyc++;
      @(negedge clk_i);
    end
    start_i = 1'b0;
    mem_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    if (state_o !== 4'd0 || halt_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_state: state=%0d halt=%b, want state=0 halt=0", state_o, halt_o);
    end
    n_total++;
    if (all_strobes() !== 15'd0 || err_o !== 2'b00 || retired_o !== 32'd0) begin
      n_bad++; $display("FAIL reset_outputs: strobes=%h err=%b ret=%0d, want 0/0/0", all_strobes(), err_o, retired_o);
    end
    n_total++;
    @(negedge clk_i);
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    if (state_o !== 4'd0 || mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL idle_hold: state=%0d req=%b, want 0/0", state_o, mem_req_o);
    end
    n_total++;
  endtask

  task automatic test_add();
    do_reset();
    start_cpu();
    mem_ready_i = 1'b1; #1;
    if (!(mem_req_o && IRWrite_o && pc_we_o && !IorD_o && ALUSrcB_o == 2'b01 && PCSource_o == 2'b00)) begin
      n_bad++; $display("FAIL add_fetch: strobes=%h, want req,IRWrite,pc_we,SrcB=01", all_strobes());
    end
    n_total++;
    @(negedge clk_i); op_i = OP_RTYPE; mem_ready_i = 1'b0; #1;
    if (ALUSrcB_o !== 2'b11 || ALUSrcA_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_bad++; $display("FAIL add_decode: SrcA=%b SrcB=%b req=%b, want 0/11/0", ALUSrcA_o, ALUSrcB_o, mem_req_o);
    end
    n_total++;
    @(negedge clk_i); #1;
    if (ALUSrcA_o !== 1'b1 || ALUSrcB_o !== 2'b00 || ALUOp_o !== 2'b10 || RegWrite_o !== 1'b0) begin
      n_bad++; $display("FAIL add_exec: SrcA=%b SrcB=%b ALUOp=%b RegWrite=%b, want 1/00/10/0", ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegWrite_o);
    end
    n_total++;
    @(negedge clk_i); #1;
    if (RegWrite_o !== 1'b1 || RegDst_o !== 1'b1 || MemtoReg_o !== 1'b0) begin
      n_bad++; $display("FAIL add_wb: RegWrite=%b RegDst=%b MemtoReg=%b, want 1/1/0", RegWrite_o, RegDst_o, MemtoReg_o);
    end
    n_total++;
    @(negedge clk_i); #1;
    if (retired_o !== 32'd1 || mem_req_o !== 1'b1 || IorD_o !== 1'b0) begin
      n_bad++; $display("FAIL add_retire: ret=%0d req=%b IorD=%b, want 1/1/0", retired_o, mem_req_o, IorD_o);
    end
    n_total++;
  endtask

  task automatic test_lw_wait();
    int cyc, reqc, wec, pcwec, regwc;
    logic m2r, dst, done;
    logic [1:0] psrc;
    do_reset();
    start_cpu();
    run_instr(OP_LW, 1'b0, 0, 3, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
    if (!done || cyc != 8) begin
      n_bad++; $display("FAIL lw_cycles: got=%0d done=%b, want 8", cyc, done);
    end
    n_total++;
    if (reqc != 5 || regwc != 1 || m2r !== 1'b1 || wec != 0) begin
      n_bad++; $display("FAIL lw_access: req=%0d regw=%0d m2r=%b we=%0d, want 5/1/1/0", reqc, regwc, m2r, wec);
    end
    n_total++;
  endtask

  task automatic test_beq();
    int cyc, reqc, wec, pcwec, regwc;
    logic m2r, dst, done;
    logic [1:0] psrc;
    do_reset();
    start_cpu();
    run_instr(OP_BEQ, 1'b1, 0, 0, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
    if (!done || cyc != 3 || pcwec != 2 || psrc !== PCSRC_ALUOUT || retired_o !== 32'd1) begin
      n_bad++; $display("FAIL beq_taken: cyc=%0d pc_we=%0d psrc=%b ret=%0d, want 3/2/01/1", cyc, pcwec, psrc, retired_o);
    end
    n_total++;
    run_instr(OP_BEQ, 1'b0, 0, 0, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
    if (!done || cyc != 3 || pcwec != 1 || retired_o !== 32'd2) begin
      n_bad++; $display("FAIL beq_not_taken: cyc=%0d pc_we=%0d ret=%0d, want 3/1/2", cyc, pcwec, retired_o);
    end
    n_total++;
    if (mem_req_o !== 1'b1 || IorD_o !== 1'b0) begin
      n_bad++; $display("FAIL beq_next_fetch: req=%b IorD=%b, want 1/0", mem_req_o, IorD_o);
    end
    n_total++;
  endtask

  task automatic test_illegal();
    do_reset();
    start_cpu();
    mem_ready_i = 1'b1;
    @(negedge clk_i); op_i = 6'b111111; mem_ready_i = 1'b0;
    @(negedge clk_i); #1;
    if (halt_o !== 1'b1 || err_o !== ERR_ILLEGAL || state_o !== 4'd15) begin
      n_bad++; $display("FAIL illegal_halt: halt=%b err=%b state=%0d, want 1/01/15", halt_o, err_o, state_o);
    end
    n_total++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      start_i = 1'b1; mem_ready_i = 1'($urandom); #1;
      if (halt_o !== 1'b1 || all_strobes() !== 15'd0) begin
        n_bad++; $display("FAIL halt_sticky[%0d]: halt=%b strobes=%h, want 1/0", i, halt_o, all_strobes());
      end
      n_total++;
    end
    start_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; #1;
    if (state_o !== 4'd0 || err_o !== ERR_NONE || halt_o !== 1'b0) begin
      n_bad++; $display("FAIL halt_reset: state=%0d err=%b halt=%b, want 0/00/0", state_o, err_o, halt_o);
    end
    n_total++;
  endtask

  task automatic test_timeout();
    int n;
    int cyc, reqc, wec, pcwec, regwc;
    logic m2r, dst, done;
    logic [1:0] psrc;
    do_reset();
    start_cpu();
    n = 0;
    for (int i = 0; i < 40 && !halt_o; i++) begin
      mem_ready_i = 1'b0; #1;
      if (mem_req_o) n++;
      @(negedge clk_i);
    end
    if (halt_o !== 1'b1 || n != 17 || err_o !== ERR_TIMEOUT) begin
      n_bad++; $display("FAIL fetch_timeout: halt=%b req_cycles=%0d err=%b, want 1/17/10", halt_o, n, err_o);
    end
    n_total++;
    do_reset();
    start_cpu();
    run_instr(OP_J, 1'b0, 16, 0, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
    if (!done || cyc != 19 || err_o !== ERR_NONE || halt_o !== 1'b0) begin
      n_bad++; $display("FAIL ready_on_limit: done=%b cyc=%0d err=%b halt=%b, want 1/19/00/0", done, cyc, err_o, halt_o);
    end
    n_total++;
    run_instr(OP_LW, 1'b0, 0, 16, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
    if (!done || cyc != 21 || halt_o !== 1'b0) begin
      n_bad++; $display("FAIL mem_ready_on_limit: done=%b cyc=%0d halt=%b, want 1/21/0", done, cyc, halt_o);
    end
    n_total++;
  endtask

  task automatic test_reset_in_mem_write();
    int cyc, reqc, wec, pcwec, regwc;
    logic m2r, dst, done, seen;
    logic [1:0] psrc;
    do_reset();
    start_cpu();
    run_instr(OP_RTYPE, 1'b0, 0, 0, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
    seen = 1'b0;
    op_i = OP_SW;
    for (int i = 0; i < 20; i++) begin
      if (mem_we_o) begin seen = 1'b1; break; end
      mem_ready_i = mem_req_o && !IorD_o;
      @(negedge clk_i);
    end
    mem_ready_i = 1'b0;
    rst_i = 1'b1; #1;
    if (!seen || mem_req_o !== 1'b1 || retired_o !== 32'd1) begin
      n_bad++; $display("FAIL mem_write_reached: seen=%b req=%b ret=%0d, want 1/1/1", seen, mem_req_o, retired_o);
    end
    n_total++;
    @(negedge clk_i);
    rst_i = 1'b0; #1;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || state_o !== 4'd0 || retired_o !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid_write: req=%b we=%b state=%0d ret=%0d, want 0/0/0/0", mem_req_o, mem_we_o, state_o, retired_o);
    end
    n_total++;
  endtask

  task automatic test_back_to_back();
    int cyc, reqc, wec, pcwec, regwc, fw, mw, exp_cyc, exp_req, exp_we, exp_pcwe, exp_rw;
    logic m2r, dst, done, zr;
    logic [1:0] psrc, exp_psrc;
    logic [5:0] op;
    logic [31:0] exp_ret;
    do_reset();
    start_cpu();
    exp_ret = 0;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 5))
        0: op = OP_RTYPE;
        1: op = OP_ADDI;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        default: op = OP_J;
      endcase
      zr = 1'($urandom);
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 4);
      run_instr(op, zr, fw, mw, cyc, reqc, wec, pcwec, regwc, m2r, dst, psrc, done);
      exp_ret++;
      exp_cyc  = ref_cpi(op) + fw + (ref_is_mem(op) ? mw : 0);
      exp_req  = fw + 1 + (ref_is_mem(op) ? mw + 1 : 0);
      exp_we   = (op == OP_SW) ? mw + 1 : 0;
      exp_pcwe = 1 + ((op == OP_J || (op == OP_BEQ && zr)) ? 1 : 0);
      exp_psrc = (op == OP_J) ? PCSRC_JUMP : (op == OP_BEQ && zr) ? PCSRC_ALUOUT : PCSRC_ALU;
      exp_rw   = (op == OP_RTYPE || op == OP_ADDI || op == OP_LW) ? 1 : 0;
      if (!done || cyc != exp_cyc || retired_o !== exp_ret) begin
        n_bad++; $display("FAIL rnd_cycles[%0d] op=%b: cyc=%0d done=%b ret=%0d, want cyc=%0d ret=%0d", k, op, cyc, done, retired_o, exp_cyc, exp_ret);
      end
      n_total++;
      if (reqc != exp_req || wec != exp_we) begin
        n_bad++; $display("FAIL rnd_mem[%0d] op=%b: req=%0d we=%0d, want %0d/%0d", k, op, reqc, wec, exp_req, exp_we);
      end
      n_total++;
      if (pcwec != exp_pcwe || psrc !== exp_psrc) begin
        n_bad++; $display("FAIL rnd_pc[%0d] op=%b: pc_we=%0d psrc=%b, want %0d/%b", k, op, pcwec, psrc, exp_pcwe, exp_psrc);
      end
      n_total++;
      if (regwc != exp_rw || (exp_rw == 1 && (m2r !== (op == OP_LW) || dst !== (op == OP_RTYPE)))) begin
        n_bad++; $display("FAIL rnd_wb[%0d] op=%b: regw=%0d m2r=%b dst=%b, want regw=%0d", k, op, regwc, m2r, dst, exp_rw);
      end
      n_total++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_reset_in_mem_write();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
